// File: rtl/bridge_pkg.sv
// bridge_pkg: AHB/AXI encodings and sequencer state type shared across the AXI-to-AHB bridge.
package bridge_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam int ID_LAST_BIT  = 8;
    localparam int ID_WRITE_BIT = 9;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } seq_state_e;
endpackage

// File: rtl/ahb_master_sequencer.sv
// ahb_master_sequencer: pops one AXI beat from the command FIFOs, runs it as a single AHB-Lite transfer, pushes the response.
module ahb_master_sequencer
    import bridge_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] axi_addr,
    input  logic        addr_fifo_empty,
    output logic        addr_r_en,
    input  logic [63:0] axi_data,
    input  logic        data_fifo_empty,
    output logic        data_r_en,
    input  logic        axi_write,
    input  logic        state_fifo_empty,
    output logic        state_r_en,
    input  logic [8:0]  axi_id,
    input  logic        id_send_fifo_empty,
    output logic        id_send_r_en,
    input  logic [2:0]  axi_size,
    input  logic        size_fifo_empty,
    output logic        size_r_en,
    output logic [63:0] axi_rdata,
    output logic        rdata_w_en,
    input  logic        rdata_fifo_full,
    output logic [1:0]  axi_resp,
    output logic        resp_w_en,
    input  logic        resp_fifo_full,
    output logic [9:0]  axi_id_resp,
    output logic        id_resp_w_en,
    input  logic        id_resp_fifo_full,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [63:0] hwdata,
    input  logic [63:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);
    seq_state_e  state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [63:0] hwdata_q, hwdata_d;
    logic [8:0]  cmd_id_q, cmd_id_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_s_q, rdata_s_d;
    logic        err_q, err_d;
    logic        err_acc_q, err_acc_d;
    logic        hold_q, hold_d;
    logic        pop_q, pop_d;
    logic        data_pop_q, data_pop_d;
    logic        rdata_w_en_q, rdata_w_en_d;
    logic        resp_w_en_q, resp_w_en_d;
    logic        id_resp_w_en_q, id_resp_w_en_d;
    logic [63:0] axi_rdata_q, axi_rdata_d;
    logic [1:0]  axi_resp_q, axi_resp_d;
    logic [9:0]  axi_id_resp_q, axi_id_resp_d;
    logic        cmd_ok, room_ok, launch, err_any;

    assign cmd_ok  = !state_fifo_empty && !addr_fifo_empty && !size_fifo_empty && !id_send_fifo_empty;
    // Writes only need response space on the last beat, where the single burst response is pushed.
    assign room_ok = axi_write
                   ? (!data_fifo_empty && (!axi_id[ID_LAST_BIT] || (!resp_fifo_full && !id_resp_fifo_full)))
                   : (!rdata_fifo_full && !resp_fifo_full && !id_resp_fifo_full);
    // hold_q covers the push-pulse cycle so the full flags seen at launch already reflect that push.
    assign launch  = cmd_ok && room_ok && !hold_q;
    assign err_any = err_acc_q | err_q;

    always_comb begin
        state_d        = state_q;
        haddr_d        = haddr_q;
        hwrite_d       = hwrite_q;
        hsize_d        = hsize_q;
        htrans_d       = htrans_q;
        hwdata_d       = hwdata_q;
        cmd_id_d       = cmd_id_q;
        wdata_d        = wdata_q;
        rdata_s_d      = rdata_s_q;
        err_d          = err_q;
        err_acc_d      = err_acc_q;
        hold_d         = 1'b0;
        pop_d          = 1'b0;
        data_pop_d     = 1'b0;
        rdata_w_en_d   = 1'b0;
        resp_w_en_d    = 1'b0;
        id_resp_w_en_d = 1'b0;
        axi_rdata_d    = axi_rdata_q;
        axi_resp_d     = axi_resp_q;
        axi_id_resp_d  = axi_id_resp_q;
        case (state_q)
            ST_IDLE: if (launch) begin
                haddr_d    = axi_addr;
                hwrite_d   = axi_write;
                hsize_d    = axi_size;
                cmd_id_d   = axi_id;
                wdata_d    = axi_data;
                htrans_d   = HTRANS_NONSEQ;
                pop_d      = 1'b1;
                data_pop_d = axi_write;
                state_d    = ST_ADDR;
            end
            ST_ADDR: if (hready) begin
                htrans_d = HTRANS_IDLE;
                hwdata_d = wdata_q;
                state_d  = ST_DATA;
            end
            ST_DATA: if (hready) begin
                rdata_s_d = hrdata;
                err_d     = hresp;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d       = ST_IDLE;
                hold_d        = 1'b1;
                axi_id_resp_d = {hwrite_q, cmd_id_q[ID_LAST_BIT], cmd_id_q[7:0]};
                if (!hwrite_q) begin
                    rdata_w_en_d   = 1'b1;
                    resp_w_en_d    = 1'b1;
                    id_resp_w_en_d = 1'b1;
                    axi_rdata_d    = rdata_s_q;
                    axi_resp_d     = err_q ? RESP_SLVERR : RESP_OKAY;
                end else if (cmd_id_q[ID_LAST_BIT]) begin
                    resp_w_en_d    = 1'b1;
                    id_resp_w_en_d = 1'b1;
                    axi_resp_d     = err_any ? RESP_SLVERR : RESP_OKAY;
                    err_acc_d      = 1'b0;
                end else begin
                    axi_id_resp_d  = axi_id_resp_q;
                    err_acc_d      = err_any;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            haddr_q        <= '0;
            hwrite_q       <= 1'b0;
            hsize_q        <= '0;
            htrans_q       <= HTRANS_IDLE;
            hwdata_q       <= '0;
            cmd_id_q       <= '0;
            wdata_q        <= '0;
            rdata_s_q      <= '0;
            err_q          <= 1'b0;
            err_acc_q      <= 1'b0;
            hold_q         <= 1'b0;
            pop_q          <= 1'b0;
            data_pop_q     <= 1'b0;
            rdata_w_en_q   <= 1'b0;
            resp_w_en_q    <= 1'b0;
            id_resp_w_en_q <= 1'b0;
            axi_rdata_q    <= '0;
            axi_resp_q     <= '0;
            axi_id_resp_q  <= '0;
        end else begin
            state_q        <= state_d;
            haddr_q        <= haddr_d;
            hwrite_q       <= hwrite_d;
            hsize_q        <= hsize_d;
            htrans_q       <= htrans_d;
            hwdata_q       <= hwdata_d;
            cmd_id_q       <= cmd_id_d;
            wdata_q        <= wdata_d;
            rdata_s_q      <= rdata_s_d;
            err_q          <= err_d;
            err_acc_q      <= err_acc_d;
            hold_q         <= hold_d;
            pop_q          <= pop_d;
            data_pop_q     <= data_pop_d;
            rdata_w_en_q   <= rdata_w_en_d;
            resp_w_en_q    <= resp_w_en_d;
            id_resp_w_en_q <= id_resp_w_en_d;
            axi_rdata_q    <= axi_rdata_d;
            axi_resp_q     <= axi_resp_d;
            axi_id_resp_q  <= axi_id_resp_d;
        end
    end

    assign addr_r_en    = pop_q;
    assign state_r_en   = pop_q;
    assign size_r_en    = pop_q;
    assign id_send_r_en = pop_q;
    assign data_r_en    = data_pop_q;
    assign rdata_w_en   = rdata_w_en_q;
    assign resp_w_en    = resp_w_en_q;
    assign id_resp_w_en = id_resp_w_en_q;
    assign axi_rdata    = axi_rdata_q;
    assign axi_resp     = axi_resp_q;
    assign axi_id_resp  = axi_id_resp_q;
    assign haddr        = haddr_q;
    assign htrans       = htrans_q;
    assign hwrite       = hwrite_q;
    assign hsize        = hsize_q;
    assign hburst       = HBURST_SINGLE;
    assign hwdata       = hwdata_q;
endmodule

// File: tb/tb_ahb_master_sequencer.sv
// tb_ahb_master_sequencer: directed beats against ahb_master_sequencer with hand-computed expectations.
module tb_ahb_master_sequencer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] axi_addr = '0;
    logic        addr_fifo_empty = 1'b1;
    logic        addr_r_en;
    logic [63:0] axi_data = '0;
    logic        data_fifo_empty = 1'b1;
    logic        data_r_en;
    logic        axi_write = 1'b0;
    logic        state_fifo_empty = 1'b1;
    logic        state_r_en;
    logic [8:0]  axi_id = '0;
    logic        id_send_fifo_empty = 1'b1;
    logic        id_send_r_en;
    logic [2:0]  axi_size = '0;
    logic        size_fifo_empty = 1'b1;
    logic        size_r_en;
    logic [63:0] axi_rdata;
    logic        rdata_w_en;
    logic        rdata_fifo_full = 1'b0;
    logic [1:0]  axi_resp;
    logic        resp_w_en;
    logic        resp_fifo_full = 1'b0;
    logic [9:0]  axi_id_resp;
    logic        id_resp_w_en;
    logic        id_resp_fifo_full = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [63:0] hwdata;
    logic [63:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    int checks = 0;
    int errors = 0;

    ahb_master_sequencer dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_addr(axi_addr), .addr_fifo_empty(addr_fifo_empty), .addr_r_en(addr_r_en),
        .axi_data(axi_data), .data_fifo_empty(data_fifo_empty), .data_r_en(data_r_en),
        .axi_write(axi_write), .state_fifo_empty(state_fifo_empty), .state_r_en(state_r_en),
        .axi_id(axi_id), .id_send_fifo_empty(id_send_fifo_empty), .id_send_r_en(id_send_r_en),
        .axi_size(axi_size), .size_fifo_empty(size_fifo_empty), .size_r_en(size_r_en),
        .axi_rdata(axi_rdata), .rdata_w_en(rdata_w_en), .rdata_fifo_full(rdata_fifo_full),
        .axi_resp(axi_resp), .resp_w_en(resp_w_en), .resp_fifo_full(resp_fifo_full),
        .axi_id_resp(axi_id_resp), .id_resp_w_en(id_resp_w_en), .id_resp_fifo_full(id_resp_fifo_full),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic heads_empty;
        addr_fifo_empty    = 1'b1;
        state_fifo_empty   = 1'b1;
        size_fifo_empty    = 1'b1;
        id_send_fifo_empty = 1'b1;
        data_fifo_empty    = 1'b1;
    endtask

    task automatic set_head(input logic [31:0] a, input logic [63:0] d, input logic w,
                            input logic [8:0] id, input logic [2:0] sz);
        axi_addr           = a;
        axi_data           = d;
        axi_write          = w;
        axi_id             = id;
        axi_size           = sz;
        addr_fifo_empty    = 1'b0;
        state_fifo_empty   = 1'b0;
        size_fifo_empty    = 1'b0;
        id_send_fifo_empty = 1'b0;
        data_fifo_empty    = !w;
    endtask

    // One beat: launch edge, wa address waits, wd data waits, RESP, push cycle, then back to idle.
    task automatic do_beat(input logic [31:0] a, input logic [63:0] d, input logic w,
                           input logic [8:0] id, input logic [2:0] sz, input int wa, input int wd,
                           input logic [63:0] rd, input logic er, input logic [1:0] eresp);
        logic push;
        push = !w || id[8];
        set_head(a, d, w, id, sz);
        tick;
        chk("pop_addr", addr_r_en, 1);
        chk("pop_state", state_r_en, 1);
        chk("pop_size", size_r_en, 1);
        chk("pop_id", id_send_r_en, 1);
        chk("pop_data", data_r_en, w);
        chk("htrans_nonseq", htrans, 2'b10);
        chk("haddr", haddr, a);
        chk("hwrite", hwrite, w);
        chk("hsize", hsize, sz);
        chk("hburst", hburst, 3'b000);
        heads_empty;
        for (int i = 0; i < wa; i++) begin
            hready = 1'b0;
            tick;
            chk("addr_wait_htrans", htrans, 2'b10);
            chk("addr_wait_haddr", haddr, a);
            chk("addr_wait_hsize", hsize, sz);
            chk("addr_wait_nopop", addr_r_en, 0);
        end
        hready = 1'b1;
        tick;
        chk("data_htrans_idle", htrans, 2'b00);
        chk("data_nopop", addr_r_en | data_r_en, 0);
        if (w) chk("hwdata", hwdata, d);
        for (int i = 0; i < wd; i++) begin
            hready = 1'b0;
            hresp  = er;
            hrdata = 64'hBAD0_BAD0_BAD0_BAD0;
            tick;
            chk("data_wait_nopush", rdata_w_en | resp_w_en | id_resp_w_en, 0);
            chk("data_wait_haddr", haddr, a);
        end
        hready = 1'b1;
        hresp  = er;
        hrdata = rd;
        tick;
        hresp  = 1'b0;
        hrdata = '0;
        chk("resp_nopush", rdata_w_en | resp_w_en | id_resp_w_en, 0);
        tick;
        chk("rdata_w_en", rdata_w_en, !w);
        chk("resp_w_en", resp_w_en, push);
        chk("id_resp_w_en", id_resp_w_en, push);
        if (!w) chk("axi_rdata", axi_rdata, rd);
        if (push) chk("axi_resp", axi_resp, eresp);
        if (push) chk("axi_id_resp", axi_id_resp, w ? {2'b11, id[7:0]} : {1'b0, id});
        tick;
        chk("push_cleared", rdata_w_en | resp_w_en | id_resp_w_en, 0);
        chk("idle_htrans", htrans, 2'b00);
    endtask

    initial begin
        #12;
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hburst", hburst, 3'b000);
        chk("rst_pops", {addr_r_en, data_r_en, state_r_en, id_send_r_en, size_r_en}, 0);
        chk("rst_push", {rdata_w_en, resp_w_en, id_resp_w_en}, 0);
        chk("rst_axi_rdata", axi_rdata, 0);
        chk("rst_axi_resp", axi_resp, 0);
        chk("rst_axi_id_resp", axi_id_resp, 0);
        tick;
        aresetn = 1'b1;
        tick;

        // Single read, zero-wait
        do_beat(32'h0000_1000, 64'h0, 1'b0, {1'b1, 8'h05}, 3'd3, 0, 0,
                64'hDEAD_BEEF_0123_4567, 1'b0, 2'b00);

        // 4-beat write, id 0x22, zero-wait: one OKAY push after beat 4
        do_beat(32'h0000_2000, 64'h1111_0000_0000_0001, 1'b1, {1'b0, 8'h22}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);
        do_beat(32'h0000_2008, 64'h2222_0000_0000_0002, 1'b1, {1'b0, 8'h22}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);
        do_beat(32'h0000_2010, 64'h3333_0000_0000_0003, 1'b1, {1'b0, 8'h22}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);
        do_beat(32'h0000_2018, 64'h4444_0000_0000_0004, 1'b1, {1'b1, 8'h22}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);

        // 4-beat write, ERROR on beat 2: sticky SLVERR on the single push
        do_beat(32'h0000_3000, 64'hA1, 1'b1, {1'b0, 8'h44}, 3'd2, 0, 0, 64'h0, 1'b0, 2'b10);
        do_beat(32'h0000_3004, 64'hA2, 1'b1, {1'b0, 8'h44}, 3'd2, 0, 1, 64'h0, 1'b1, 2'b10);
        do_beat(32'h0000_3008, 64'hA3, 1'b1, {1'b0, 8'h44}, 3'd2, 0, 0, 64'h0, 1'b0, 2'b10);
        do_beat(32'h0000_300C, 64'hA4, 1'b1, {1'b1, 8'h44}, 3'd2, 0, 0, 64'h0, 1'b0, 2'b10);

        // Following write burst is clean again
        do_beat(32'h0000_4000, 64'hB1, 1'b1, {1'b0, 8'h33}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);
        do_beat(32'h0000_4008, 64'hB2, 1'b1, {1'b1, 8'h33}, 3'd3, 0, 0, 64'h0, 1'b0, 2'b00);

        // Read with wait states: 3 in ADDR, 2 in DATA
        do_beat(32'h0000_5000, 64'h0, 1'b0, {1'b0, 8'h7E}, 3'd2, 3, 2,
                64'h0F0F_F0F0_1234_5678, 1'b0, 2'b00);

        // Read ERROR is reported per beat
        do_beat(32'h0000_5100, 64'h0, 1'b0, {1'b1, 8'h7E}, 3'd3, 0, 1,
                64'h5555_AAAA_5555_AAAA, 1'b1, 2'b10);

        // Read blocked by a full rdata FIFO
        rdata_fifo_full = 1'b1;
        set_head(32'h0000_6000, 64'h0, 1'b0, {1'b1, 8'h09}, 3'd3);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("full_nopop", addr_r_en | state_r_en, 0);
            chk("full_htrans", htrans, 2'b00);
        end
        rdata_fifo_full = 1'b0;
        do_beat(32'h0000_6000, 64'h0, 1'b0, {1'b1, 8'h09}, 3'd3, 0, 0,
                64'h0000_0000_CAFE_F00D, 1'b0, 2'b00);

        // Reset asserted during DATA drops the beat
        set_head(32'h0000_7000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, {1'b1, 8'h11}, 3'd3);
        tick;
        chk("rstmid_launch", addr_r_en, 1);
        heads_empty;
        tick;
        hready = 1'b0;
        tick;
        aresetn = 1'b0;
        #1;
        chk("rstmid_htrans", htrans, 2'b00);
        chk("rstmid_haddr", haddr, 0);
        chk("rstmid_hwdata", hwdata, 0);
        chk("rstmid_hsize", hsize, 0);
        chk("rstmid_pops", {addr_r_en, data_r_en, state_r_en, id_send_r_en, size_r_en}, 0);
        hready = 1'b1;
        hrdata = 64'h1234_1234_1234_1234;
        tick;
        tick;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rstmid_nopush", {rdata_w_en, resp_w_en, id_resp_w_en}, 0);
            chk("rstmid_idle", htrans, 2'b00);
        end
        chk("rstmid_axi_rdata", axi_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_master_sequencer.md
# ahb_master_sequencer

Drains the per-beat command FIFOs filled by the AXI front end (address, write data, direction, ID, size), executes each beat as a single non-pipelined AHB-Lite transfer, and pushes the results into the response FIFOs drained by the AXI response side. It is the only AHB master in the bridge and sequences one beat at a time.

## Interface
- No parameters; all widths are fixed by the bridge: address 32, data 64, AXI ID 8.
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axi_addr / addr_fifo_empty / addr_r_en  in 32 / in 1 / out 1  address FIFO head, first-word fall-through (FWFT), and pop
- axi_data / data_fifo_empty / data_r_en  in 64 / in 1 / out 1  write-data FIFO (FWFT)
- axi_write / state_fifo_empty / state_r_en  in 1 / in 1 / out 1  direction FIFO (FWFT); 1 = write
- axi_id / id_send_fifo_empty / id_send_r_en  in 9 / in 1 / out 1  ID FIFO (FWFT); {last, id[7:0]}
- axi_size / size_fifo_empty / size_r_en  in 3 / in 1 / out 1  size FIFO (FWFT)
- axi_rdata / rdata_w_en / rdata_fifo_full  out 64 / out 1 / in 1  read-data push
- axi_resp / resp_w_en / resp_fifo_full  out 2 / out 1 / in 1  response push
- axi_id_resp / id_resp_w_en / id_resp_fifo_full  out 10 / out 1 / in 1  response ID push; {is_write, last, id[7:0]}
- haddr out 32, htrans out 2, hwrite out 1, hsize out 3, hburst out 3, hwdata out 64  AHB master outputs
- hrdata in 64, hready in 1, hresp in 1  AHB-Lite slave return (1 = ERROR)

## Operation
- FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE, launch condition: all of the following hold.
  - state, addr, size and id_send FIFOs are all non-empty.
  - If the head is a write, the data FIFO is also non-empty.
  - If the head is a read, none of the rdata, resp or id_resp FIFOs is full.
  - If the head is a write with last = 1, neither the resp nor the id_resp FIFO is full.
  - A write with last = 0 needs no response space.
- On launch: register haddr, hwrite, hsize, cmd_id (9 bits) and wdata_q from the FIFO heads. Set htrans = NONSEQ. Go to ADDR.
- ADDR:
  - The pop pulses assert for exactly one cycle, in the first ADDR cycle: state_r_en, addr_r_en, size_r_en, id_send_r_en, plus data_r_en for writes.
  - Hold the address phase while hready = 0.
  - When hready = 1: htrans becomes IDLE, hwdata is driven from wdata_q, and the FSM goes to DATA.
- DATA:
  - Wait for hready = 1.
  - Sample hrdata, and sample hresp as err = hresp. The first, hready = 0 cycle of an ERROR response is ignored.
  - Go to RESP.
- RESP: one cycle, then IDLE. In this cycle the FSM registers the push pulses, so they are visible for one cycle in the following IDLE cycle:
  - Read: rdata_w_en, resp_w_en and id_resp_w_en = 1. axi_rdata = sampled hrdata. axi_resp = SLVERR if err, else OKAY. axi_id_resp = {0, cmd_id[8], cmd_id[7:0]}.
  - Write:
    - err_acc |= err.
    - If cmd_id[8] = 1: resp_w_en and id_resp_w_en = 1, axi_resp = SLVERR if (err_acc | err), axi_id_resp = {1, 1, cmd_id[7:0]}, and err_acc is cleared.
    - If cmd_id[8] = 0: no push.
- IDLE does not launch in the cycle a push pulse is high, so the full flags it sees are current. Launch is first evaluated one cycle later.
- hburst is constant SINGLE. Each beat's address is taken verbatim from the FIFO; this block computes no addresses.
- An AHB ERROR never aborts the AXI burst. Later beats still execute, and errors are reported per beat (read) or sticky per burst (write).

## Timing
- Every output is registered.
- Reset values:
  - htrans = IDLE; haddr, hwrite, hsize, hwdata = 0; hburst = SINGLE.
  - All r_en and w_en = 0; axi_rdata, axi_resp, axi_id_resp = 0.
  - err_acc = 0; FSM in IDLE.
- Minimum beat cost, zero-wait slave: launch cycle, 1 ADDR, 1 DATA, 1 RESP, then the push-pulse cycle. The next launch is possible the cycle after that: 5 cycles per beat.
- Each added hready-low cycle adds one cycle.
- Reset asserted mid-transfer: immediate return to the reset values. The in-flight beat is dropped, with no push and no further pop. FIFO contents are owned and reset elsewhere.
- Empty or full at launch only delays the launch; no partial pops ever occur.

## Structure
- Shared package bridge_pkg holds:
  - HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HBURST_SINGLE = 3'b000.
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - The FSM state type.
  - Bit positions of the last flag (8) and the is_write flag (9) in the ID entries.
- Single flat module; no sub-module.

## Test plan
- Read beat, addr 0x1000, size 3, id {1, 0x05}, zero-wait hrdata 0xDEAD_BEEF_0123_4567 -> one push: rdata = 0xDEAD_BEEF_0123_4567, resp = 00, id_resp = 10'b0_1_0000_0101. The five pop pulses coincide in the first ADDR cycle.
- 4-beat write, id 0x22, zero-wait -> four AHB NONSEQ transfers with matching hwdata, and exactly one resp/id_resp push (OKAY, 10'b1_1_0010_0010) after beat 4.
- 4-beat write, ERROR on beat 2 -> all 4 beats execute; the single push has resp = 10 (SLVERR); a following write burst reports OKAY.
- hready held low 3 cycles in ADDR and 2 cycles in DATA -> address and control stable throughout; the beat completes 5 cycles later than zero-wait.
- Read head with rdata_fifo_full = 1 -> no pop and htrans stays IDLE until full deasserts; launch occurs the next cycle.
- aresetn pulsed low during DATA -> outputs return to reset values immediately, and no push occurs for that beat.
